// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared constants and types for the instruction fetch unit and its queue.
//   RESET_PC_DEFAULT : default reset PC
//   NOP_INSTR        : instruction driven when no valid instruction is present
//   PC_INC           : PC step per fetched word
//   DROP_W           : width of the stale-response drop counter
//   fetch_entry_t    : {pc, instr} record stored in the instruction queue
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] PC_INC           = 32'd4;

   // Stale responses can pile up across back-to-back redirects while fresh
   // requests keep issuing, so this is sized well past any queue depth.
   localparam int DROP_W = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small in-order queue of fetch_entry_t records (DEPTH must be a power of 2).
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     flush_in       : empties the queue; overrides push and pop
//     push_in        : write push_data_in at the tail (ignored when full
//                      unless a pop happens in the same cycle)
//     pop_in         : drop the head entry (ignored when empty)
//     head_out       : current head entry
//     full_out       : DEPTH entries held
//     empty_out      : no entries held
//     count_out      : current occupancy
// -----------------------------------------------------------------------------
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush_in,
   input  logic                           push_in,
   input  fetch_entry_t                   push_data_in,
   input  logic                           pop_in,
   output fetch_entry_t                   head_out,
   output logic                           full_out,
   output logic                           empty_out,
   output logic [$clog2(DEPTH+1)-1:0]     count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]            wr_q, wr_d;
   logic [PW-1:0]            rd_q, rd_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     do_push, do_pop;

   assign empty_out = (cnt_q == '0);
   assign full_out  = (cnt_q == CW'(DEPTH));
   assign count_out = cnt_q;
   assign head_out  = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_pop  = pop_in && !empty_out;
      // A full queue still accepts a push when the head leaves this cycle.
      do_push = push_in && (!full_out || do_pop);
      if (flush_in) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data_in;
            wr_d        = wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Sequential instruction fetcher with an in-order instruction queue and
//   redirect support. Stale responses belonging to requests issued before a
//   redirect are counted and discarded as they return.
//   Parameters:
//     RESET_PC    : word-aligned PC loaded at reset
//     QUEUE_DEPTH : instruction queue entries, 2 or 4
//   Ports:
//     clk, rst_n                        : clock, asynchronous active-low reset
//     imem_req_valid_out/ready_in       : fetch request handshake
//     imem_addr_out                     : fetch word address
//     imem_rsp_valid_in/data_in         : in-order read responses
//     redirect_in, redirect_pc_in       : redirect pulse and target
//     instr_out/pc_out/valid_out        : queue head toward the decoder
//     instr_ready_in                    : decoder consumes the head
//     perf_fetch_cnt_out                : delivered instruction count
//                                         (only with FETCH_PERF_EN defined)
//   Optional feature macro: FETCH_PERF_EN
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid_out,
   input  logic        imem_req_ready_in,
   output logic [31:0] imem_addr_out,
   input  logic        imem_rsp_valid_in,
   input  logic [31:0] imem_rsp_data_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc_out,
   output logic        instr_valid_out,
   input  logic        instr_ready_in
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt_out
`endif
);

   localparam int CW = $clog2(QUEUE_DEPTH+1);

   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       rsp_pc_q, rsp_pc_d;   // PC of the next non-stale response
   logic [CW-1:0]     outst_q, outst_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   fetch_entry_t  head, push_entry;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt;
   logic          pop, push, req_fire, rsp_keep, rsp_drop;
   logic [CW:0]   credit;
   logic [31:0]   redirect_pc;
   logic [1:0]    unused_pc_bits;

   assign redirect_pc    = {redirect_pc_in[31:2], 2'b00};
   assign unused_pc_bits = redirect_pc_in[1:0];

   assign instr_valid_out = !fifo_empty;
   assign instr_out       = instr_valid_out ? head.instr : NOP_INSTR;
   assign instr_pc_out    = instr_valid_out ? head.pc    : 32'h0;
   assign imem_addr_out   = fetch_pc_q;

   assign pop      = instr_valid_out && instr_ready_in;
   assign rsp_drop = imem_rsp_valid_in && (drop_q != '0);
   assign rsp_keep = imem_rsp_valid_in && (drop_q == '0);
   // A redirect discards the response arriving in the same cycle.
   assign push     = rsp_keep && !redirect_in && (!fifo_full || pop);

   assign push_entry.pc    = rsp_pc_q;
   assign push_entry.instr = imem_rsp_data_in;

   // Slots are committed to queued entries plus in-flight requests. A slot
   // freed by this cycle's pop counts as free, which is what allows one
   // instruction per cycle with a single-cycle memory.
   assign credit             = {1'b0, fifo_cnt} + {1'b0, outst_q} - (CW+1)'(pop);
   assign imem_req_valid_out = rst_n && !redirect_in && (credit < (CW+1)'(QUEUE_DEPTH));
   assign req_fire           = imem_req_valid_out && imem_req_ready_in;

   always_comb begin
      fetch_pc_d = req_fire ? fetch_pc_q + PC_INC : fetch_pc_q;
      rsp_pc_d   = rsp_keep ? rsp_pc_q + PC_INC : rsp_pc_q;
      outst_d    = outst_q + CW'(req_fire) - CW'(rsp_keep);
      drop_d     = drop_q - DROP_W'(rsp_drop);
      if (redirect_in) begin
         // Every request still in flight becomes stale; a kept response
         // returning this very cycle is already accounted for.
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         outst_d    = '0;
         drop_d     = drop_q - DROP_W'(rsp_drop) + DROP_W'(outst_q) - DROP_W'(rsp_keep);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_in     (redirect_in),
      .push_in      (push),
      .push_data_in (push_entry),
      .pop_in       (pop),
      .head_out     (head),
      .full_out     (fifo_full),
      .empty_out    (fifo_empty),
      .count_out    (fifo_cnt)
   );

`ifdef FETCH_PERF_EN
   // Counts every output handshake, including one in a redirect cycle.
   logic [31:0] perf_cnt_q, perf_cnt_d;

   always_comb begin
      perf_cnt_d = perf_cnt_q + 32'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_cnt_q <= '0;
      else        perf_cnt_q <= perf_cnt_d;
   end

   assign perf_fetch_cnt_out = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table (hand-derived waveforms for
// start-up, back-pressure, redirect with stale responses and PC wrap), then
// random traffic checked every cycle against a queue-based reference model.
module tb_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid_out, imem_req_ready_in = 1'b0;
   logic [31:0] imem_addr_out;
   logic        imem_rsp_valid_in = 1'b0;
   logic [31:0] imem_rsp_data_in = '0;
   logic        redirect_in = 1'b0;
   logic [31:0] redirect_pc_in = '0;
   logic [31:0] instr_out, instr_pc_out;
   logic        instr_valid_out, instr_ready_in = 1'b0;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt_out;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .imem_req_valid_out (imem_req_valid_out),
      .imem_req_ready_in  (imem_req_ready_in),
      .imem_addr_out      (imem_addr_out),
      .imem_rsp_valid_in  (imem_rsp_valid_in),
      .imem_rsp_data_in   (imem_rsp_data_in),
      .redirect_in        (redirect_in),
      .redirect_pc_in     (redirect_pc_in),
      .instr_out          (instr_out),
      .instr_pc_out       (instr_pc_out),
      .instr_valid_out    (instr_valid_out),
      .instr_ready_in     (instr_ready_in)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt_out (perf_fetch_cnt_out)
`endif
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: memory requests in flight (with a stale mark set by
   // redirects), the delivered-instruction queue, and the next fetch PC.
   typedef struct {logic [31:0] addr; bit stale; int rdy;} mreq_t;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
   mreq_t       memq[$];
   ent_t        mq[$];
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_perf = 32'h0;
   int          cyc = 0;

   task automatic model_reset();
      memq.delete();
      mq.delete();
      m_pc   = 32'h0;
      m_perf = 32'h0;
   endtask

   task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rq_rdy,
                        input bit in_rdy, input bit rsp_en, input bit tchk,
                        input bit t_req, input logic [31:0] t_addr,
                        input bit t_val, input logic [31:0] t_pc);
      bit   rsp, m_val, m_pop, m_req;
      int   ns;
      ent_t ne;
      mreq_t e;
      @(negedge clk);
      rsp = rsp_en && (memq.size() > 0) && (memq[0].rdy <= cyc);
      redirect_in       = redir;
      redirect_pc_in    = tgt;
      imem_req_ready_in = rq_rdy;
      instr_ready_in    = in_rdy;
      imem_rsp_valid_in = rsp;
      imem_rsp_data_in  = rsp ? memdata(memq[0].addr) : $urandom;
      #1;
      ns = 0;
      foreach (memq[i]) if (!memq[i].stale) ns++;
      m_val = (mq.size() > 0);
      m_pop = m_val && in_rdy;
      m_req = !redir && ((mq.size() - int'(m_pop) + ns) < DEPTH);
      chk("req_valid", 32'(imem_req_valid_out), 32'(m_req));
      chk("req_addr", imem_addr_out, m_pc);
      chk("instr_valid", 32'(instr_valid_out), 32'(m_val));
      chk("instr", instr_out, m_val ? mq[0].instr : NOP);
      chk("instr_pc", instr_pc_out, m_val ? mq[0].pc : 32'h0);
`ifdef FETCH_PERF_EN
      chk("perf_cnt", perf_fetch_cnt_out, m_perf);
`endif
      if (tchk) begin
         chk("vec_req_valid", 32'(imem_req_valid_out), 32'(t_req));
         chk("vec_addr", imem_addr_out, t_addr);
         chk("vec_valid", 32'(instr_valid_out), 32'(t_val));
         chk("vec_pc", instr_pc_out, t_pc);
      end
      @(posedge clk);
      cyc++;
      if (m_pop) begin
         mq.delete(0);
         m_perf += 32'd1;
      end
      if (rsp) begin
         e = memq.pop_front();
         if (!e.stale && !redir) begin
            ne.pc    = e.addr;
            ne.instr = memdata(e.addr);
            mq.push_back(ne);
         end
      end
      if (redir) begin
         mq.delete();
         foreach (memq[i]) memq[i].stale = 1'b1;
         m_pc = {tgt[31:2], 2'b00};
      end else if (m_req && rq_rdy) begin
         e.addr  = m_pc;
         e.stale = 1'b0;
         e.rdy   = cyc;
         memq.push_back(e);
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, 32'(imem_req_valid_out), 32'h0);
      chk({tag, "_addr"}, imem_addr_out, 32'h0);
      chk({tag, "_instr_valid"}, 32'(instr_valid_out), 32'h0);
      chk({tag, "_instr"}, instr_out, NOP);
      chk({tag, "_instr_pc"}, instr_pc_out, 32'h0);
`ifdef FETCH_PERF_EN
      chk({tag, "_perf"}, perf_fetch_cnt_out, 32'h0);
`endif
   endtask

   task automatic release_reset();
      // Release mid high-phase so the first cycle() call covers the cycle
      // right after release.
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   typedef struct {
      bit redir; logic [31:0] tgt; bit rq; bit ir; bit rsp;
      bit req_v; logic [31:0] addr; bit iv; logic [31:0] pc;
   } vec_t;
   vec_t vt[28];

   function automatic vec_t mk(input bit redir, input logic [31:0] tgt, input bit ir,
                               input bit rsp, input bit req_v, input logic [31:0] addr,
                               input bit iv, input logic [31:0] pc);
      vec_t v;
      v.redir = redir; v.tgt = tgt; v.rq = 1'b1; v.ir = ir; v.rsp = rsp;
      v.req_v = req_v; v.addr = addr; v.iv = iv; v.pc = pc;
      return v;
   endfunction

   initial begin
      // Start-up with a 1-cycle memory and the decoder always ready.
      vt[0]  = mk(0, 0, 1, 1, 1, 32'h0,  0, 32'h0);
      vt[1]  = mk(0, 0, 1, 1, 1, 32'h4,  0, 32'h0);
      vt[2]  = mk(0, 0, 1, 1, 1, 32'h8,  1, 32'h0);
      vt[3]  = mk(0, 0, 1, 1, 1, 32'hC,  1, 32'h4);
      // Decoder stalls for 10 cycles: fetching stops, head holds PC 8.
      for (int i = 4; i < 14; i++) vt[i] = mk(0, 0, 0, 1, 0, 32'h10, 1, 32'h8);
      vt[14] = mk(0, 0, 1, 1, 1, 32'h10, 1, 32'h8);
      vt[15] = mk(0, 0, 1, 1, 1, 32'h14, 1, 32'hC);
      vt[16] = mk(0, 0, 1, 1, 1, 32'h18, 1, 32'h10);
      // Memory holds two responses, then a redirect to 0x102.
      vt[17] = mk(0, 0, 1, 0, 1, 32'h1C, 1, 32'h14);
      vt[18] = mk(1, 32'h102, 1, 0, 0, 32'h20, 0, 32'h0);
      vt[19] = mk(0, 0, 1, 1, 1, 32'h100, 0, 32'h0);
      vt[20] = mk(0, 0, 1, 1, 1, 32'h104, 0, 32'h0);
      vt[21] = mk(0, 0, 1, 1, 0, 32'h108, 0, 32'h0);
      vt[22] = mk(0, 0, 1, 1, 1, 32'h108, 1, 32'h100);
      // Redirect near the top of memory: the fetch PC wraps to 0.
      vt[23] = mk(1, 32'hFFFF_FFF8, 1, 1, 0, 32'h10C, 1, 32'h104);
      vt[24] = mk(0, 0, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0);
      vt[25] = mk(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
      vt[26] = mk(0, 0, 1, 1, 1, 32'h0, 1, 32'hFFFF_FFF8);
      vt[27] = mk(0, 0, 1, 1, 1, 32'h4, 1, 32'hFFFF_FFFC);

      // Reset state.
      #12;
      check_reset_outputs("reset");
      model_reset();
      release_reset();

      foreach (vt[i])
         cycle(vt[i].redir, vt[i].tgt, vt[i].rq, vt[i].ir, vt[i].rsp, 1'b1,
               vt[i].req_v, vt[i].addr, vt[i].iv, vt[i].pc);

      // Random traffic: request back-pressure, variable memory latency,
      // decoder stalls and redirects to arbitrary targets.
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0,
               1'b0, 32'h0, 1'b0, 32'h0);

      // Asynchronous reset mid-operation; memory is reset alongside.
      @(negedge clk);
      #2 rst_n = 1'b0;
      redirect_in       = 1'b0;
      imem_rsp_valid_in = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      repeat (2) @(posedge clk);
      release_reset();

      for (int i = 0; i < 500; i++)
         cycle($urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 1) != 0,
               $urandom_range(0, 4) != 0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC loaded at reset; must be word-aligned.
REQ-002 Parameter QUEUE_DEPTH, default 2, sets the instruction queue entries; legal values are 2 or 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port imem_req_valid_out, output, 1 bit: fetch request valid.
REQ-006 Port imem_req_ready_in, input, 1 bit: memory accepts the request.
REQ-007 Port imem_addr_out, output, 32 bits: fetch word address, bits [1:0] always 0.
REQ-008 Port imem_rsp_valid_in, input, 1 bit: read data valid; responses arrive in order, at most one per cycle, at least 1 cycle after acceptance.
REQ-009 Port imem_rsp_data_in, input, 32 bits: instruction word.
REQ-010 Port redirect_in, input, 1 bit: branch/jump redirect pulse from downstream.
REQ-011 Port redirect_pc_in, input, 32 bits: redirect target.
REQ-012 Port instr_out, output, 32 bits: instruction to the decoder's instr_in.
REQ-013 Port instr_pc_out, output, 32 bits: PC of instr_out.
REQ-014 Port instr_valid_out, output, 1 bit: instr_out is valid.
REQ-015 Port instr_ready_in, input, 1 bit: decoder consumes the instruction.

Function
REQ-016 A request handshake is imem_req_valid_out and imem_req_ready_in high on the same edge; on a handshake, fetch_pc increments by 4 and wraps 32'hFFFF_FFFC to 0.
REQ-017 imem_req_valid_out is high only when (queue occupancy + outstanding) < QUEUE_DEPTH and no redirect is present in the same cycle.
REQ-018 Each accepted response is pushed with its PC into a FIFO queue; instr_out, instr_pc_out and instr_valid_out are driven from the queue head.
REQ-019 An output handshake is instr_valid_out and instr_ready_in high together, and pops the head.
REQ-020 Best-case latency is 1 cycle from response to instr_valid_out; with instr_ready_in held high and a 1-cycle memory, throughput is 1 instruction per cycle.
REQ-021 Push and pop may occur in the same cycle when the queue is full; occupancy is then unchanged.
REQ-022 On redirect_in, the next edge flushes the queue, sets fetch_pc to {redirect_pc_in[31:2],2'b00}, and adds the current outstanding count to a drop counter.
REQ-023 While the drop counter is nonzero, responses are discarded and decrement it; a fresh request may issue in the cycle after a redirect.
REQ-024 redirect_in has priority over push, pop and request; an output handshake in the redirect cycle is still considered consumed.
REQ-025 A redirect that arrives while the drop counter is nonzero accumulates into it.
REQ-026 instr_out is 32'h0000_0013 (NOP) whenever instr_valid_out is low.

Reset
REQ-027 While rst_n is low: fetch_pc = RESET_PC; queue empty; outstanding and drop counters 0; imem_req_valid_out = 0; instr_valid_out = 0; instr_out = NOP; instr_pc_out = 0.
REQ-028 Reset asserted mid-operation abandons outstanding requests; responses that arrive after release are not discarded, so the memory must be reset together with this block.

Configuration
REQ-029 With FETCH_PERF_EN defined: output perf_fetch_cnt_out, 32 bits, counts output handshakes, resets to 0, wraps at 2^32, and is not cleared by redirect.
REQ-030 Without FETCH_PERF_EN: the port and the counter do not exist.

Structure
REQ-031 A shared package holds RESET_PC_DEFAULT, the NOP encoding 32'h0000_0013, the fetch_entry_t typedef {pc[31:0], instr[31:0]}, and the PC increment constant 4.
REQ-032 The queue is a sub-module, fetch_fifo, parameterised by depth and carrying fetch_entry_t, with push/pop/full/empty.

Verification
REQ-033 Reset release, 1-cycle memory, instr_ready_in = 1: imem_addr_out = 0,4,8,...; the first instr_valid_out appears 2 cycles after release with instr_pc_out = 0.
REQ-034 instr_ready_in = 0 for 10 cycles: requests stop after QUEUE_DEPTH accepts; after ready returns, instructions are delivered in order with no loss.
REQ-035 Redirect to 32'h0000_0102 with 2 outstanding requests: both stale responses are dropped; the next request address is 32'h0000_0100; the next delivered instr_pc_out is 32'h0000_0100.
REQ-036 fetch_pc = 32'hFFFF_FFFC accepted: the next request address is 32'h0000_0000.
REQ-037 Queue full with simultaneous push and pop: occupancy is unchanged and order is preserved; imem_req_ready_in toggling randomly gives no duplicated or skipped PCs.
REQ-038 With FETCH_PERF_EN: 5 handshakes, then a redirect, then 3 handshakes gives perf_fetch_cnt_out = 8.
